icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
//   Direct-mapped, one-word-per-line instruction cache between fetch (inf) and the memory controller (mct).
//   Serves fetch hits in 1 cycle and forwards misses to mct as single-word reads.
//   Fills the line on return and keeps hit/miss counters for performance runs.
// PARAMETERS
//   IDX_W   6   index bits; 2**IDX_W lines; tag width = 30-IDX_W
// PORTS
//   clk       in   1   clock; all state changes on posedge
//   rst       in   1   synchronous, active-low reset (reset when rst==0 at posedge)
//   fl        in   1   flush: invalidate all lines (fence.i / reload)
//   if_e      in   1   fetch request valid; requester holds if_a stable until if_ok
//   if_a      in   32  fetch address, word aligned; a[1:0] ignored
//   if_ok     out  1   one-cycle pulse: if_n valid for current request
//   if_n      out  32  instruction word
//   mc_e      out  1   read request to mct, held high until mc_ok
//   mc_a      out  32  read address to mct, {if_a[31:2],2'b00}
//   mc_ok     in   1   mct read complete, mc_n valid this cycle
//   mc_n      in   32  word returned by mct
//   hit_cnt   out  32  number of hits since reset, wraps at 2**32
//   mis_cnt   out  32  number of misses since reset, wraps at 2**32
// BEHAVIOUR
//   - Storage: val[2**IDX_W] (flops), tag[] (30-IDX_W bits), dat[] (32 bits); read combinationally.
//   - idx = if_a[IDX_W+1:2]; tg = if_a[31:IDX_W+2]; hit = val[idx] && tag[idx]==tg.
//   - Reset (rst==0): state=IDLE, all val=0, if_ok=0, if_n=0, mc_e=0, mc_a=0, counters=0.
//     Applies mid-miss: mc_e drops next cycle, no fill, no if_ok.
//   - FSM states: IDLE, MISS, DROP.
//   - IDLE, if_e=1, hit, fl=0 at cycle t: at t+1 if_ok=1, if_n=dat[idx]; hit_cnt+1. Stay IDLE.
//     Back-to-back hits give one word per cycle.
//   - IDLE, if_e=1, miss or fl=1 at cycle t: at t+1 mc_e=1, mc_a=aligned if_a; mis_cnt+1; go MISS.
//     A request with fl=1 is always treated as a miss.
//   - MISS, mc_ok=1 at cycle u: write dat=mc_n, tag=tg, val=1 at idx; at u+1 if_ok=1, if_n=mc_n,
//     mc_e=0; go IDLE. The next request is accepted no earlier than u+1.
//   - MISS, if_e=0 (fetch redirect/abort): go DROP. mct cannot abort, so mc_e stays high.
//   - DROP, mc_ok=1: line still filled; if_ok stays 0; mc_e=0 next cycle; go IDLE.
//   - MISS/DROP, mc_ok=0: hold; mc_a stable; if_a changes ignored.
//   - fl=1 in any state: all val cleared at next edge. If fl coincides with a fill write, fl wins
//     (line not valid), but the MISS response is still delivered.
//   - if_ok never asserted in two consecutive cycles for one request; never without a prior if_e.
//   - mc_e never rises while a previous mct read is outstanding.
//   - Counters count accepted requests only; no saturation.
// TESTING
//   1. Reset, if_e=1, if_a=0x0000_0100, mc_ok after 3 cycles with mc_n=0x0000_0013
//      -> mc_a=0x100; if_ok one cycle after mc_ok, if_n=0x13; mis_cnt=1.
//   2. Repeat 0x100 -> if_ok next cycle, if_n=0x13, mc_e stays 0, hit_cnt=1;
//      0x100 and 0x104 back-to-back -> if_ok on consecutive cycles.
//   3. Conflict: fill 0x100, then 0x100+(4<<IDX_W)=0x200 (IDX_W=6), then 0x100
//      -> three misses, mis_cnt=3, each reaching mct.
//   4. Fill 0x100, pulse fl=1, request 0x100 -> miss to mct; fl on the same cycle as mc_ok
//      -> if_n still correct, following 0x100 misses.
//   5. Miss on 0x300, drop if_e before mc_ok -> mc_e held until mc_ok, no if_ok;
//      later 0x300 hits.
//   6. rst=0 for one cycle while MISS -> mc_e=0, if_ok=0, counters=0 next cycle;
//      late mc_ok ignored; 0x300 then misses.

Source files
------------

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache
//   Direct-mapped instruction cache, one 32-bit word per line, sitting between
//   the fetch unit and the memory controller. Hits answer in one cycle, misses
//   become single-word reads to the memory controller and fill the line when
//   the word comes back. Hit and miss counters run freely for performance runs.
//
// Ports
//   clk      in   1   clock, all state changes on the rising edge
//   rst      in   1   synchronous active-low reset
//   fl       in   1   flush, invalidates every line at the next edge
//   if_e     in   1   fetch request valid, if_a held until if_ok
//   if_a     in   32  fetch address (bits 1:0 ignored)
//   if_ok    out  1   one-cycle pulse, if_n carries the requested word
//   if_n     out  32  instruction word
//   mc_e     out  1   read request to the memory controller, held until mc_ok
//   mc_a     out  32  word-aligned read address
//   mc_ok    in   1   memory read complete, mc_n valid this cycle
//   mc_n     in   32  word returned by the memory controller
//   hit_cnt  out  32  accepted requests that hit, wraps
//   mis_cnt  out  32  accepted requests that missed, wraps
// -----------------------------------------------------------------------------
module icache #(
    parameter int IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fl,
    input  logic        if_e,
    input  logic [31:0] if_a,
    output logic        if_ok,
    output logic [31:0] if_n,
    output logic        mc_e,
    output logic [31:0] mc_a,
    input  logic        mc_ok,
    input  logic [31:0] mc_n,
    output logic [31:0] hit_cnt,
    output logic [31:0] mis_cnt
);

    localparam int NL = 1 << IDX_W;
    localparam int TW = 30 - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MISS,
        S_DROP
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [NL-1:0]      r_val;
    logic [TW-1:0]      r_tag [NL];
    logic [31:0]        r_dat [NL];

    logic               r_ifOk;
    logic [31:0]        r_ifN;
    logic               r_mcE;
    logic [29:0]        r_mcA;
    logic [31:0]        r_hitCnt;
    logic [31:0]        r_misCnt;

    logic [IDX_W-1:0]   w_idx;
    logic [TW-1:0]      w_tg;
    logic               w_hit;
    logic [IDX_W-1:0]   w_fillIdx;
    logic [TW-1:0]      w_fillTag;
    logic               w_takeHit;
    logic               w_takeMiss;
    logic               w_fill;
    logic               w_respond;
    logic               w_unusedA;

    assign w_idx     = if_a[IDX_W+1:2];
    assign w_tg      = if_a[31:IDX_W+2];
    assign w_hit     = r_val[w_idx] && (r_tag[w_idx] == w_tg);

    // The outstanding read is addressed by the latched mc_a, not by if_a,
    // because the requester may move if_a while the read is in flight.
    assign w_fillIdx = r_mcA[IDX_W-1:0];
    assign w_fillTag = r_mcA[29:IDX_W];

    assign w_unusedA = ^if_a[1:0];

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A returning word always wins over an abort seen in
    // the same cycle, so the controller is never left with a dangling read.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (if_e && (fl || !w_hit)) begin
                    w_nextState = S_MISS;
                end
            end
            S_MISS: begin
                if (mc_ok) begin
                    w_nextState = S_IDLE;
                end else if (!if_e) begin
                    w_nextState = S_DROP;
                end
            end
            S_DROP: begin
                if (mc_ok) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Output decode. A flush on the request cycle forces a miss so that a
    // reload after fence.i always goes to memory.
    always_comb begin
        w_takeHit  = (r_state == S_IDLE) && if_e && w_hit && !fl;
        w_takeMiss = (r_state == S_IDLE) && if_e && (fl || !w_hit);
        w_fill     = (r_state != S_IDLE) && mc_ok;
        w_respond  = (r_state == S_MISS) && mc_ok && if_e;
    end

    // Registered outputs, valid bits and counters. Flush beats a same-cycle
    // fill so the refilled line is not marked valid, while the word itself
    // is still returned to the requester.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_val    <= '0;
            r_ifOk   <= 1'b0;
            r_ifN    <= '0;
            r_mcE    <= 1'b0;
            r_mcA    <= '0;
            r_hitCnt <= '0;
            r_misCnt <= '0;
        end else begin
            r_ifOk <= w_takeHit || w_respond;
            if (w_takeHit) begin
                r_ifN <= r_dat[w_idx];
            end else if (w_respond) begin
                r_ifN <= mc_n;
            end
            if (w_takeMiss) begin
                r_mcE <= 1'b1;
                r_mcA <= if_a[31:2];
            end else if (w_fill) begin
                r_mcE <= 1'b0;
            end
            if (w_takeHit) begin
                r_hitCnt <= r_hitCnt + 32'd1;
            end
            if (w_takeMiss) begin
                r_misCnt <= r_misCnt + 32'd1;
            end
            if (fl) begin
                r_val <= '0;
            end else if (w_fill) begin
                r_val[w_fillIdx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (rst && w_fill) begin
            r_tag[w_fillIdx] <= w_fillTag;
            r_dat[w_fillIdx] <= mc_n;
        end
    end

    assign if_ok   = r_ifOk;
    assign if_n    = r_ifN;
    assign mc_e    = r_mcE;
    assign mc_a    = {r_mcA, 2'b00};
    assign hit_cnt = r_hitCnt;
    assign mis_cnt = r_misCnt;

endmodule

// File: tb/tb_icache.sv
// -----------------------------------------------------------------------------
// tb_icache
//   Directed bench for icache with IDX_W=6. Inputs are driven 1 ns after each
//   rising edge and outputs are sampled at the same point, so every check sees
//   the state produced by the preceding edge.
// -----------------------------------------------------------------------------
module tb_icache;

    logic        clk;
    logic        rst;
    logic        fl;
    logic        if_e;
    logic [31:0] if_a;
    logic        if_ok;
    logic [31:0] if_n;
    logic        mc_e;
    logic [31:0] mc_a;
    logic        mc_ok;
    logic [31:0] mc_n;
    logic [31:0] hit_cnt;
    logic [31:0] mis_cnt;

    int nChecks;
    int nErrors;

    icache #(.IDX_W(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .fl      (fl),
        .if_e    (if_e),
        .if_a    (if_a),
        .if_ok   (if_ok),
        .if_n    (if_n),
        .mc_e    (mc_e),
        .mc_a    (mc_a),
        .mc_ok   (mc_ok),
        .mc_n    (mc_n),
        .hit_cnt (hit_cnt),
        .mis_cnt (mis_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against the bench's expected value.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request that must miss, return the word after waitCycles
    // extra cycles, and check the memory request and the response.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input int waitCycles);
        if_e = 1'b1;
        if_a = addr;
        tick();
        checkOutput("miss mc_e", {31'd0, mc_e}, 32'd1);
        checkOutput("miss mc_a", mc_a, {addr[31:2], 2'b00});
        checkOutput("miss no early if_ok", {31'd0, if_ok}, 32'd0);
        repeat (waitCycles) tick();
        mc_ok = 1'b1;
        mc_n  = data;
        tick();
        checkOutput("fill if_ok", {31'd0, if_ok}, 32'd1);
        checkOutput("fill if_n", if_n, data);
        checkOutput("fill mc_e low", {31'd0, mc_e}, 32'd0);
        mc_ok = 1'b0;
        mc_n  = 32'd0;
        if_e  = 1'b0;
    endtask

    initial begin
        nChecks = 0;
        nErrors = 0;
        rst   = 1'b0;
        fl    = 1'b0;
        if_e  = 1'b0;
        if_a  = 32'd0;
        mc_ok = 1'b0;
        mc_n  = 32'd0;
        tick();
        tick();

        // Reset state
        checkOutput("rst if_ok", {31'd0, if_ok}, 32'd0);
        checkOutput("rst if_n", if_n, 32'd0);
        checkOutput("rst mc_e", {31'd0, mc_e}, 32'd0);
        checkOutput("rst mc_a", mc_a, 32'd0);
        checkOutput("rst hit_cnt", hit_cnt, 32'd0);
        checkOutput("rst mis_cnt", mis_cnt, 32'd0);
        rst = 1'b1;
        tick();

        // Cold miss on 0x100, memory answers after 3 cycles
        if_e = 1'b1;
        if_a = 32'h0000_0100;
        tick();
        checkOutput("t1 mc_e", {31'd0, mc_e}, 32'd1);
        checkOutput("t1 mc_a", mc_a, 32'h0000_0100);
        checkOutput("t1 mis_cnt", mis_cnt, 32'd1);
        tick();
        tick();
        checkOutput("t1 mc_e held", {31'd0, mc_e}, 32'd1);
        checkOutput("t1 no if_ok while waiting", {31'd0, if_ok}, 32'd0);
        mc_ok = 1'b1;
        mc_n  = 32'h0000_0013;
        tick();
        checkOutput("t1 if_ok", {31'd0, if_ok}, 32'd1);
        checkOutput("t1 if_n", if_n, 32'h0000_0013);
        checkOutput("t1 mc_e low", {31'd0, mc_e}, 32'd0);
        mc_ok = 1'b0;
        mc_n  = 32'd0;
        if_e  = 1'b0;
        tick();
        checkOutput("t1 if_ok single pulse", {31'd0, if_ok}, 32'd0);

        // Hit on 0x100, then back-to-back hits on 0x100 and 0x104
        if_e = 1'b1;
        if_a = 32'h0000_0100;
        tick();
        checkOutput("t2 hit if_ok", {31'd0, if_ok}, 32'd1);
        checkOutput("t2 hit if_n", if_n, 32'h0000_0013);
        checkOutput("t2 hit mc_e", {31'd0, mc_e}, 32'd0);
        checkOutput("t2 hit_cnt", hit_cnt, 32'd1);
        if_e = 1'b0;
        tick();
        applyStimulus(32'h0000_0104, 32'h0000_0017, 1);
        tick();
        if_e = 1'b1;
        if_a = 32'h0000_0100;
        tick();
        checkOutput("t2 b2b first if_ok", {31'd0, if_ok}, 32'd1);
        checkOutput("t2 b2b first if_n", if_n, 32'h0000_0013);
        if_a = 32'h0000_0104;
        tick();
        checkOutput("t2 b2b second if_ok", {31'd0, if_ok}, 32'd1);
        checkOutput("t2 b2b second if_n", if_n, 32'h0000_0017);
        if_e = 1'b0;
        tick();
        checkOutput("t2 b2b end if_ok", {31'd0, if_ok}, 32'd0);
        checkOutput("t2 hit_cnt final", hit_cnt, 32'd3);
        checkOutput("t2 mis_cnt", mis_cnt, 32'd2);

        // Conflict on index 0: 0x200 evicts 0x100, 0x100 misses again
        applyStimulus(32'h0000_0200, 32'h0000_0022, 1);
        applyStimulus(32'h0000_0100, 32'h0000_0013, 0);
        tick();
        checkOutput("t3 mis_cnt", mis_cnt, 32'd4);

        // Flush pulse, then 0x100 must miss
        fl = 1'b1;
        tick();
        fl = 1'b0;
        applyStimulus(32'h0000_0100, 32'h0000_0013, 1);
        tick();
        // Flush on request forces a miss, flush again on the fill cycle
        if_e = 1'b1;
        if_a = 32'h0000_0100;
        fl   = 1'b1;
        tick();
        checkOutput("t4 forced miss mc_e", {31'd0, mc_e}, 32'd1);
        checkOutput("t4 forced miss if_ok", {31'd0, if_ok}, 32'd0);
        fl = 1'b0;
        tick();
        mc_ok = 1'b1;
        mc_n  = 32'h0000_0013;
        fl    = 1'b1;
        tick();
        checkOutput("t4 fl+fill if_ok", {31'd0, if_ok}, 32'd1);
        checkOutput("t4 fl+fill if_n", if_n, 32'h0000_0013);
        mc_ok = 1'b0;
        mc_n  = 32'd0;
        fl    = 1'b0;
        if_e  = 1'b0;
        tick();
        applyStimulus(32'h0000_0100, 32'h0000_0013, 0);
        tick();
        checkOutput("t4 mis_cnt", mis_cnt, 32'd7);

        // Abort during a miss on 0x300: read stays up until memory answers
        if_e = 1'b1;
        if_a = 32'h0000_0300;
        tick();
        checkOutput("t5 mc_e", {31'd0, mc_e}, 32'd1);
        if_e = 1'b0;
        if_a = 32'hDEAD_0000;
        tick();
        checkOutput("t5 mc_e held after abort", {31'd0, mc_e}, 32'd1);
        checkOutput("t5 mc_a stable", mc_a, 32'h0000_0300);
        tick();
        checkOutput("t5 mc_e still held", {31'd0, mc_e}, 32'd1);
        mc_ok = 1'b1;
        mc_n  = 32'h0000_0033;
        tick();
        checkOutput("t5 dropped no if_ok", {31'd0, if_ok}, 32'd0);
        checkOutput("t5 dropped mc_e low", {31'd0, mc_e}, 32'd0);
        mc_ok = 1'b0;
        mc_n  = 32'd0;
        tick();
        checkOutput("t5 no late if_ok", {31'd0, if_ok}, 32'd0);
        if_e = 1'b1;
        if_a = 32'h0000_0300;
        tick();
        checkOutput("t5 later hit if_ok", {31'd0, if_ok}, 32'd1);
        checkOutput("t5 later hit if_n", if_n, 32'h0000_0033);
        checkOutput("t5 hit_cnt", hit_cnt, 32'd4);
        checkOutput("t5 mis_cnt", mis_cnt, 32'd8);
        if_e = 1'b0;
        tick();

        // Reset in the middle of a miss, late mc_ok ignored
        if_e = 1'b1;
        if_a = 32'h0000_0500;
        tick();
        checkOutput("t6 miss mc_e", {31'd0, mc_e}, 32'd1);
        rst = 1'b0;
        tick();
        checkOutput("t6 rst mc_e", {31'd0, mc_e}, 32'd0);
        checkOutput("t6 rst if_ok", {31'd0, if_ok}, 32'd0);
        checkOutput("t6 rst mc_a", mc_a, 32'd0);
        checkOutput("t6 rst hit_cnt", hit_cnt, 32'd0);
        checkOutput("t6 rst mis_cnt", mis_cnt, 32'd0);
        rst   = 1'b1;
        if_e  = 1'b0;
        mc_ok = 1'b1;
        mc_n  = 32'h0000_0055;
        tick();
        checkOutput("t6 late mc_ok if_ok", {31'd0, if_ok}, 32'd0);
        checkOutput("t6 late mc_ok mc_e", {31'd0, mc_e}, 32'd0);
        mc_ok = 1'b0;
        mc_n  = 32'd0;
        tick();
        applyStimulus(32'h0000_0300, 32'h0000_0033, 0);
        tick();
        checkOutput("t6 mis_cnt after reset", mis_cnt, 32'd1);
        checkOutput("t6 hit_cnt after reset", hit_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
